seq_chunk_adder: RTL and testbench

Parametrised multi-cycle ripple adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, and keeps the carry in a register between chunks. It is the sequential, width-generic successor to the team's fixed 4-bit ripple-carry adder. Datapaths use it where a full-width carry chain would not meet timing or area limits.

---
 rtl/seq_chunk_adder.sv | 152 +++++++++++++++
 tb/tb_seq_chunk_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder/subtractor.
// Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first. The carry
// is kept in a register between chunks, so the combinational carry chain is
// only CHUNK bits long. An operation takes N = WIDTH/CHUNK RUN cycles plus one
// DONE cycle. sum/cout/overflow are loaded only on entry to DONE.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    // Operand shift registers: the chunk being added always sits in the low bits.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // B, already inverted for subtraction
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_work;   // partial results shift in from the top
    logic             r_a_msb;  // sign of A, kept for overflow after A shifts out
    logic             r_b_msb;  // sign of B'
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk_ext;
    logic [WIDTH-1:0] w_work_next;

    assign w_last = (r_idx == LAST_IDX);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is honoured in IDLE and DONE, ignored in RUN.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One CHUNK-bit slice of the ripple chain plus the shifted working register.
    always_comb begin
        w_chunk_ext = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};
        w_work_next = (r_work >> CHUNK)
                    | (WIDTH'(w_chunk_ext[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Datapath: capture on accept, one chunk per RUN cycle, publish on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_work  <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_work  <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunk_ext[CHUNK];
            r_idx   <= r_idx + 1'b1;
            r_work  <= w_work_next;
            if (w_last) begin
                r_sum  <= w_work_next;
                r_cout <= w_chunk_ext[CHUNK];
                r_ovf  <= (r_a_msb == r_b_msb) && (w_work_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed cases on a 16/4 instance checked by a
// per-cycle monitor against an arithmetic model, plus four WIDTH=8 lanes
// (CHUNK 1,2,4,8) driven with random operations.
module tb_seq_chunk_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lanes_done = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result as {overflow, cout, sum} for a w-bit operation, from plain integer
    // arithmetic: unsigned sum/difference for sum and carry, signed range for overflow.
    function automatic logic [17:0] model(input int w, input longint unsigned ma,
                                          input longint unsigned mb, input logic mc,
                                          input logic ms);
        longint unsigned m, half, r;
        longint sa, sb, s;
        logic co, ov;
        m    = (64'd1 << w) - 1;
        half = 64'd1 << (w - 1);
        sa   = (ma >= half) ? longint'(ma) - longint'(m) - 1 : longint'(ma);
        sb   = (mb >= half) ? longint'(mb) - longint'(m) - 1 : longint'(mb);
        if (ms) begin
            r  = (ma - mb) & m;
            co = (ma >= mb);
            s  = sa - sb;
        end else begin
            r  = (ma + mb + 64'(mc)) & m;
            co = (ma + mb + 64'(mc)) > m;
            s  = sa + sb + longint'({63'd0, mc});
        end
        ov = (s >= longint'(half)) || (s < -longint'(half));
        return {ov, co, r[15:0]};
    endfunction

    // ---------------- main 16/4 instance ----------------
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;
    logic          mon_en;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    typedef struct packed {
        int          acc;   // cycle count at the accepting edge
        logic [17:0] exp;
    } op_t;

    op_t         q[$];
    logic [17:0] held = '0;

    // Per-cycle compare: busy in the N cycles after the accepting edge, done
    // exactly N edges after it, result equal to the last completed operation.
    always @(negedge clk) begin : mon
        logic de, be;
        if (mon_en && !rst) begin
            de = (q.size() > 0) && (cyc == q[0].acc + N);
            be = (q.size() > 0) && (cyc >= q[$].acc) && (cyc < q[$].acc + N);
            check("mon_busy", busy, be);
            check("mon_done", done, de);
            if (de) begin
                held = q[0].exp;
                void'(q.pop_front());
            end
            check("mon_result", {overflow, cout, sum}, held);
        end
    end

    task automatic start_op(input logic [15:0] oa, input logic [15:0] ob,
                            input logic oc, input logic os);
        op_t op;
        start  = 1'b1;
        a      = oa;
        b      = ob;
        cin    = oc;
        sub    = os;
        op.acc = cyc + 1;
        op.exp = model(W, oa, ob, oc, os);
        q.push_back(op);
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < N + 4) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob,
                          input logic oc, input logic os, output logic [17:0] res);
        int k;
        start_op(oa, ob, oc, os);
        wait_done(k);
        check("done_latency", k, N);
        res = {overflow, cout, sum};
    endtask

    initial begin : main
        logic [17:0] res;
        int k;
        int t_first;
        op_t op;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0; mon_en = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", {overflow, cout, sum}, 0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, res); check("add_basic",   res, 18'h05555);
        @(negedge clk);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, res); check("carry_wrap",  res, 18'h10000);
        @(negedge clk);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, res); check("cin_wrap",    res, 18'h10000);
        @(negedge clk);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, res); check("add_ovf",     res, 18'h28000);
        @(negedge clk);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, res); check("sub_ovf",     res, 18'h37FFF);
        @(negedge clk);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, res); check("sub_borrow",  res, 18'h0FFFE);

        // start pulsed two cycles into RUN must be ignored
        @(negedge clk);
        start_op(16'h0100, 16'h0023, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("start_ignored", {done, overflow, cout, sum}, 19'h40123);

        // start held high through DONE: back-to-back operation
        @(negedge clk);
        start = 1'b1; a = 16'd5; b = 16'd6; cin = 1'b0; sub = 1'b0;
        op.acc = cyc + 1; op.exp = model(W, 5, 6, 1'b0, 1'b0); q.push_back(op);
        @(negedge clk);
        a = 16'd1; b = 16'd2;
        repeat (N) @(negedge clk);
        check("b2b_first_done", done, 1);
        check("b2b_first_res", {overflow, cout, sum}, 18'h0000B);
        t_first = cyc;
        op.acc = cyc + 1; op.exp = model(W, 1, 2, 1'b0, 1'b0); q.push_back(op);
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("b2b_gap", cyc - t_first, N + 1);
        check("b2b_second_res", {overflow, cout, sum}, 18'h00003);

        // asynchronous reset in RUN cycle 2
        @(negedge clk);
        start_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        @(posedge clk);
        #1 check("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", {overflow, cout, sum}, 0);
        q.delete();
        held = '0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_rst", done, 0);
        end
        rst = 1'b0;
        run_op(16'h2222, 16'h1111, 1'b0, 1'b1, res); check("after_rst_sub", res, 18'h11111);

        // random traffic, mixed gaps including back-to-back from DONE
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), res);
        end
        repeat (3) @(negedge clk);

        k = 0;
        while (lanes_done < 4 && k < 30000) begin
            @(negedge clk);
            k++;
        end
        check("lanes_finished", lanes_done, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- WIDTH=8 parameter sweep lanes ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int LC = 1 << gi;
        localparam int LN = 8 / LC;

        logic       l_rst;
        logic       l_start;
        logic       l_sub;
        logic [7:0] l_a;
        logic [7:0] l_b;
        logic       l_cin;
        logic       l_busy;
        logic       l_done;
        logic [7:0] l_sum;
        logic       l_cout;
        logic       l_ovf;

        seq_chunk_adder #(.WIDTH(8), .CHUNK(LC)) u_lane (
            .clk(clk), .rst(l_rst), .start(l_start), .sub(l_sub), .a(l_a), .b(l_b),
            .cin(l_cin), .busy(l_busy), .done(l_done), .sum(l_sum), .cout(l_cout),
            .overflow(l_ovf)
        );

        initial begin : lane_drv
            logic [7:0]  ra, rb;
            logic        rc, rs;
            logic [17:0] exp;
            int          lat;
            l_rst = 1'b1; l_start = 1'b0; l_sub = 1'b0; l_a = '0; l_b = '0; l_cin = 1'b0;
            repeat (3) @(negedge clk);
            l_rst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                exp = model(8, ra, rb, rc, rs);
                @(negedge clk);
                l_start = 1'b1; l_a = ra; l_b = rb; l_cin = rc; l_sub = rs;
                @(negedge clk);
                l_start = 1'b0; l_a = 8'($urandom); l_b = 8'($urandom);
                lat = 0;
                while (!l_done && lat < LN + 4) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("lane%0d_latency", LC), lat, LN);
                check($sformatf("lane%0d_result", LC), {l_ovf, l_cout, 8'h00, l_sum}, exp);
            end
            lanes_done++;
        end
    end

endmodule
